ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Multi-cycle multiply/divide unit in the EX stage, fed directly by the id_ex pipeline register.
//  Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) into HI/LO, and handles MTHI/MTLO.
//  Asserts ex_stall to freeze PC, if_id and id_ex while an operation is in flight.
// PARAMETERS
//  S  32  datapath width; iteration count = S
// PORTS
//  clk              in   1    pipeline clock; all state changes on posedge
//  reset            in   1    synchronous, active-low; 0 at posedge = reset
//  ex_valid         in   1    id_ex holds a real instruction (0 = bubble, op ignored)
//  ex_op            in   3    0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 reserved(=NOP)
//  ex_ReadRegister1 in   S    rs operand (multiplicand / dividend / MTHI-MTLO source)
//  ex_ReadRegister2 in   S    rt operand (multiplier / divisor)
//  ex_stall         out  1    hold upstream stages and id_ex this cycle
//  ex_hi            out  S    HI register
//  ex_lo            out  S    LO register
//  ex_busy          out  1    state is ITER or FIXUP
//  ex_divzero       out  1    1-cycle pulse in DONE when completed op was DIV/DIVU with rt==0
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, HI=LO=0, counter=0, internal regs=0; outputs read
//   ex_stall=0, ex_busy=0, ex_divzero=0 the following cycle. Reset mid-operation aborts it,
//   HI/LO not updated with partial results.
//  start = ex_valid && ex_op in {1..4} && state==IDLE.
//  FSM: IDLE -> ITER on start (latch |rs|,|rt| for signed ops, raw for unsigned; latch signs, op)
//       ITER -> ITER while counter<S-1; counter++ each cycle; -> FIXUP when counter==S-1
//       FIXUP -> DONE: apply sign correction, write HI/LO at this edge
//       DONE -> IDLE unconditionally (instruction leaves id_ex at this edge; no restart)
//  ex_stall (combinational) = start || state==ITER || state==FIXUP; 0 in DONE and idle.
//  Latency: instruction occupies EX S+3 cycles, ex_stall high S+2 of them; HI/LO visible in DONE.
//  Multiply: shift-add on 2S-bit accumulator; {HI,LO} = full 2S-bit product.
//   MULT: result negated (two's complement, 2S bits) when sign(rs)^sign(rt).
//  Divide: restoring, one quotient bit per ITER cycle; LO=quotient, HI=remainder.
//   DIV: quotient negated if sign(rs)^sign(rt); remainder takes sign of rs.
//   DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0 (natural wrap, no trap).
//   rt==0 (DIV or DIVU): LO=all ones, HI=rs (unmodified), sign fixup skipped; ex_divzero=1 in DONE.
//  MTHI/MTLO: in IDLE with ex_valid, write HI (resp. LO) = rs at the edge; no stall; other reg kept.
//  ex_valid==0 or op 0/7: no state change. ex_op/operands ignored outside IDLE (id_ex is frozen).
//  HI/LO change only at FIXUP->DONE edge, MTHI/MTLO edge, or reset.
// TESTING
//  MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> stall 34 cycles, DONE: HI=0xFFFFFFFE LO=0x00000001
//  MULT rs=-3 rt=7 -> HI=0xFFFFFFFF LO=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> HI=0x40000000 LO=0
//  DIV rs=-7 rt=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU 100/7 -> LO=14 HI=2
//  DIVU rs=5 rt=0 -> LO=0xFFFFFFFF HI=5, ex_divzero pulses 1 cycle in DONE only
//  MTHI 0x1234 then MTLO 0x5678 back-to-back -> no stall, HI=0x1234 LO=0x5678; ex_valid=0 op=1 -> no start
//  reset=0 during ITER cycle 10 of MULT -> next cycle IDLE, stall=0, HI=LO=0; new DIV then runs S+3 cycles

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit: MULT/MULTU/DIV/DIVU one bit per cycle into HI/LO,
// plus single-cycle MTHI/MTLO. Holds the front of the pipeline while an operation runs.
module ex_muldiv #(
   parameter int S = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ex_valid,
   input  logic [2:0]   ex_op,
   input  logic [S-1:0] ex_ReadRegister1,
   input  logic [S-1:0] ex_ReadRegister2,
   output logic         ex_stall,
   output logic [S-1:0] ex_hi,
   output logic [S-1:0] ex_lo,
   output logic         ex_busy,
   output logic         ex_divzero
);

   localparam int CW = (S > 1) ? $clog2(S) : 1;

   typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

   state_t         state, next_state;
   logic [CW-1:0]  count;
   logic [2*S-1:0] acc;
   logic [S-1:0]   opa, opb;
   logic           sign_a, sign_b, is_div;
   logic           divzero;

   logic           start, signed_op, last_iter;
   logic [S-1:0]   abs_rs, abs_rt;
   logic [S:0]     mul_sum, div_shift, div_diff;
   logic [2*S-1:0] mul_next, div_next;
   logic [S-1:0]   fix_hi, fix_lo;

   assign signed_op = (ex_op == 3'd1) || (ex_op == 3'd3);
   assign start     = ex_valid && (ex_op >= 3'd1) && (ex_op <= 3'd4) && (state == IDLE);
   assign last_iter = (count == CW'(S-1));
   assign abs_rs    = (signed_op && ex_ReadRegister1[S-1]) ? -ex_ReadRegister1 : ex_ReadRegister1;
   assign abs_rt    = (signed_op && ex_ReadRegister2[S-1]) ? -ex_ReadRegister2 : ex_ReadRegister2;

   // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, dividend/quotient}
   assign mul_sum   = {1'b0, acc[2*S-1:S]} + {1'b0, opa};
   assign mul_next  = acc[0] ? {mul_sum, acc[S-1:1]} : {1'b0, acc[2*S-1:1]};
   assign div_shift = {acc[2*S-1:S], acc[S-1]};
   assign div_diff  = div_shift - {1'b0, opb};
   assign div_next  = div_diff[S] ? {div_shift[S-1:0], acc[S-2:0], 1'b0}
                                  : {div_diff[S-1:0], acc[S-2:0], 1'b1};

   assign ex_stall   = start || (state == ITER) || (state == FIXUP);
   assign ex_busy    = (state == ITER) || (state == FIXUP);
   assign ex_divzero = divzero;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ITER;
         ITER:    if (last_iter) next_state = FIXUP;
         FIXUP:   next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Sign correction; a zero divisor reports all-ones quotient and the original dividend
   always_comb begin
      fix_hi = acc[2*S-1:S];
      fix_lo = acc[S-1:0];
      if (!is_div) begin
         if (sign_a ^ sign_b) {fix_hi, fix_lo} = -acc;
      end else if (opb == '0) begin
         fix_lo = '1;
         fix_hi = sign_a ? -opa : opa;
      end else begin
         if (sign_a ^ sign_b) fix_lo = -acc[S-1:0];
         if (sign_a)          fix_hi = -acc[2*S-1:S];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count   <= '0;
         acc     <= '0;
         opa     <= '0;
         opb     <= '0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         is_div  <= 1'b0;
         divzero <= 1'b0;
         ex_hi   <= '0;
         ex_lo   <= '0;
      end else begin
         divzero <= 1'b0;
         case (state)
            IDLE: begin
               count <= '0;
               if (start) begin
                  opa    <= abs_rs;
                  opb    <= abs_rt;
                  sign_a <= signed_op && ex_ReadRegister1[S-1];
                  sign_b <= signed_op && ex_ReadRegister2[S-1];
                  is_div <= (ex_op == 3'd3) || (ex_op == 3'd4);
                  acc    <= {{S{1'b0}}, ((ex_op == 3'd3) || (ex_op == 3'd4)) ? abs_rs : abs_rt};
               end else if (ex_valid && ex_op == 3'd5) begin
                  ex_hi <= ex_ReadRegister1;
               end else if (ex_valid && ex_op == 3'd6) begin
                  ex_lo <= ex_ReadRegister1;
               end
            end
            ITER: begin
               acc   <= is_div ? div_next : mul_next;
               count <= last_iter ? '0 : count + 1'b1;
            end
            FIXUP: begin
               ex_hi   <= fix_hi;
               ex_lo   <= fix_lo;
               divzero <= is_div && (opb == '0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: expected HI/LO/divzero come from a 64-bit arithmetic model,
// queued when an operation is issued and popped when the unit reaches DONE.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic [2:0]  ex_op;
   logic [31:0] ex_ReadRegister1, ex_ReadRegister2;
   logic        ex_stall, ex_busy, ex_divzero;
   logic [31:0] ex_hi, ex_lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   ex_muldiv #(.S(32)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
      .ex_ReadRegister1(ex_ReadRegister1), .ex_ReadRegister2(ex_ReadRegister2),
      .ex_stall(ex_stall), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .ex_busy(ex_busy), .ex_divzero(ex_divzero)
   );

   always #5 clk = ~clk;

   // Reference arithmetic done in 64 bits, independent of the iterative datapath
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      exp_t        e;
      longint      p, q, r;
      logic [63:0] u;
      e.hi = '0; e.lo = '0; e.dz = 1'b0;
      case (op)
         3'd1: begin
            p = longint'($signed(rs)) * longint'($signed(rt));
            {e.hi, e.lo} = p;
         end
         3'd2: begin
            u = {32'd0, rs} * {32'd0, rt};
            {e.hi, e.lo} = u;
         end
         default: begin
            if (rt == 32'd0) begin
               e.lo = '1; e.hi = rs; e.dz = 1'b1;
            end else if (op == 3'd3) begin
               q = longint'($signed(rs)) / longint'($signed(rt));
               r = longint'($signed(rs)) % longint'($signed(rt));
               e.lo = q[31:0]; e.hi = r[31:0];
            end else begin
               e.lo = rs / rt; e.hi = rs % rt;
            end
         end
      endcase
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Issue a MULT/MULTU/DIV/DIVU from idle, count stall cycles, then score HI/LO in DONE
   task automatic applyStimulus(input string name, input logic [2:0] op,
                                input logic [31:0] rs, input logic [31:0] rt);
      exp_t e;
      int   n;
      sb.push_back(model(op, rs, rt));
      ex_valid = 1'b1; ex_op = op; ex_ReadRegister1 = rs; ex_ReadRegister2 = rt;
      #1;
      n = 0;
      while (ex_stall === 1'b1 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      checkOutput({name, "_stall_cycles"}, n, 32'd34);
      e = sb.pop_front();
      checkOutput({name, "_hi"}, ex_hi, e.hi);
      checkOutput({name, "_lo"}, ex_lo, e.lo);
      checkOutput({name, "_divzero"}, {31'd0, ex_divzero}, {31'd0, e.dz});
      checkOutput({name, "_busy_done"}, {31'd0, ex_busy}, 32'd0);
      ex_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput({name, "_divzero_after"}, {31'd0, ex_divzero}, 32'd0);
      checkOutput({name, "_stall_after"}, {31'd0, ex_stall}, 32'd0);
   endtask

   initial begin
      exp_t e;
      reset = 1'b0; ex_valid = 1'b0; ex_op = 3'd0;
      ex_ReadRegister1 = '0; ex_ReadRegister2 = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      checkOutput("reset_stall", {31'd0, ex_stall}, 32'd0);
      checkOutput("reset_busy", {31'd0, ex_busy}, 32'd0);
      checkOutput("reset_divzero", {31'd0, ex_divzero}, 32'd0);
      checkOutput("reset_hi", ex_hi, 32'd0);
      checkOutput("reset_lo", ex_lo, 32'd0);

      applyStimulus("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      applyStimulus("mult_m3x7", 3'd1, 32'hFFFF_FFFD, 32'd7);
      applyStimulus("mult_minsq", 3'd1, 32'h8000_0000, 32'h8000_0000);
      applyStimulus("mult_mixed", 3'd1, 32'd12345, 32'hFFFF_FF85);
      applyStimulus("div_m7d2", 3'd3, 32'hFFFF_FFF9, 32'd2);
      applyStimulus("div_7dm2", 3'd3, 32'd7, 32'hFFFF_FFFE);
      applyStimulus("divu_100d7", 3'd4, 32'd100, 32'd7);
      applyStimulus("divu_5d0", 3'd4, 32'd5, 32'd0);
      applyStimulus("div_m9d0", 3'd3, 32'hFFFF_FFF7, 32'd0);
      applyStimulus("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      applyStimulus("divu_big", 3'd4, 32'hF000_0001, 32'h0001_0003);

      // MTHI then MTLO back to back: single-cycle, no stall
      sb.push_back('{hi: 32'h0000_1234, lo: 32'h0000_5678, dz: 1'b0});
      ex_valid = 1'b1; ex_op = 3'd5; ex_ReadRegister1 = 32'h0000_1234;
      #1 checkOutput("mthi_stall", {31'd0, ex_stall}, 32'd0);
      @(posedge clk); #1;
      ex_op = 3'd6; ex_ReadRegister1 = 32'h0000_5678;
      #1 checkOutput("mtlo_stall", {31'd0, ex_stall}, 32'd0);
      checkOutput("mthi_hi", ex_hi, 32'h0000_1234);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      e = sb.pop_front();
      checkOutput("mt_hi", ex_hi, e.hi);
      checkOutput("mt_lo", ex_lo, e.lo);

      // Bubble carrying a MULT opcode must not start anything
      ex_op = 3'd1; ex_ReadRegister1 = 32'd3; ex_ReadRegister2 = 32'd4;
      #1 checkOutput("bubble_stall", {31'd0, ex_stall}, 32'd0);
      @(posedge clk); #1;
      checkOutput("bubble_busy", {31'd0, ex_busy}, 32'd0);
      checkOutput("bubble_hi", ex_hi, 32'h0000_1234);
      checkOutput("bubble_lo", ex_lo, 32'h0000_5678);

      // Reset during the 10th ITER cycle of a MULT aborts it and clears HI/LO
      ex_valid = 1'b1; ex_op = 3'd1; ex_ReadRegister1 = 32'd1000; ex_ReadRegister2 = 32'd1000;
      @(posedge clk); #1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      checkOutput("abort_busy_before", {31'd0, ex_busy}, 32'd1);
      reset = 1'b0; ex_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      checkOutput("abort_stall", {31'd0, ex_stall}, 32'd0);
      checkOutput("abort_busy", {31'd0, ex_busy}, 32'd0);
      checkOutput("abort_hi", ex_hi, 32'd0);
      checkOutput("abort_lo", ex_lo, 32'd0);
      @(posedge clk); #1;
      applyStimulus("div_after_abort", 3'd3, 32'hFFFF_FF9C, 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
